// File: rtl/pwm_generator_unit_if.sv
// Control/output bundle for the PWM generator: enable, duty request and PWM output.
interface pwm_generator_unit_if #(
  parameter int unsigned PWM_RESOLUTION_c = 10
);
  logic                        EN_i;
  logic [PWM_RESOLUTION_c-1:0] PWM_VALUE_i;
  logic                        PWM_o;

  modport master (output EN_i, output PWM_VALUE_i, input PWM_o);
  modport slave  (input EN_i, input PWM_VALUE_i, output PWM_o);
endinterface

// File: rtl/pwm_generator_unit.sv
// Fixed-frequency PWM generator: prescaler, N-bit step counter, double-buffered duty
// and a registered comparator output gated by an enable.
module pwm_generator_unit #(
  parameter int unsigned CLK_FREQ_c       = 100_000_000,
  parameter int unsigned PWM_FREQ_c       = 100,
  parameter int unsigned PWM_RESOLUTION_c = 10
) (
  input logic                 CLK_i,
  input logic                 RESET_n_i,
  pwm_generator_unit_if.slave pwm_io
);

  localparam int unsigned PRESC_c = CLK_FREQ_c / (PWM_FREQ_c * (2 ** PWM_RESOLUTION_c));
  localparam int unsigned PrescW  = (PRESC_c > 1) ? $clog2(PRESC_c) : 1;

  if (PRESC_c < 1) begin : g_presc_check
    $error("pwm_generator_unit: clock too slow for requested PWM frequency and resolution");
  end

  logic [PrescW-1:0]           presc_cnt_q, presc_cnt_d;
  logic [PWM_RESOLUTION_c-1:0] step_cnt_q, step_cnt_d;
  logic [PWM_RESOLUTION_c-1:0] duty_shadow_q, duty_shadow_d;
  logic                        en_prev_q;
  logic                        pwm_q, pwm_d;

  always_comb begin
    presc_cnt_d   = presc_cnt_q;
    step_cnt_d    = step_cnt_q;
    duty_shadow_d = duty_shadow_q;
    pwm_d         = pwm_q;

    if (!pwm_io.EN_i) begin
      // Abandon the period at once; the shadow duty is kept.
      presc_cnt_d = '0;
      step_cnt_d  = '0;
      pwm_d       = 1'b0;
    end else if (!en_prev_q) begin
      presc_cnt_d   = '0;
      step_cnt_d    = '0;
      duty_shadow_d = pwm_io.PWM_VALUE_i;
      pwm_d         = 1'b0;
    end else begin
      if (presc_cnt_q == PrescW'(PRESC_c - 1)) begin
        presc_cnt_d = '0;
        step_cnt_d  = step_cnt_q + 1'b1;
        // Period boundary: the new duty governs the whole next period.
        if (step_cnt_q == '1) begin
          duty_shadow_d = pwm_io.PWM_VALUE_i;
        end
      end else begin
        presc_cnt_d = presc_cnt_q + 1'b1;
      end
      // Compare against the values being loaded so there is no one-period skew.
      pwm_d = (step_cnt_d < duty_shadow_d);
    end
  end

  always_ff @(posedge CLK_i or negedge RESET_n_i) begin
    if (!RESET_n_i) begin
      presc_cnt_q   <= '0;
      step_cnt_q    <= '0;
      duty_shadow_q <= '0;
      en_prev_q     <= 1'b0;
      pwm_q         <= 1'b0;
    end else begin
      presc_cnt_q   <= presc_cnt_d;
      step_cnt_q    <= step_cnt_d;
      duty_shadow_q <= duty_shadow_d;
      en_prev_q     <= pwm_io.EN_i;
      pwm_q         <= pwm_d;
    end
  end

  assign pwm_io.PWM_o = pwm_q;

endmodule

// File: tb/tb_pwm_generator_unit.sv
// Directed bench for pwm_generator_unit, scaled to 3 clocks per step and 1024 steps
// (3072-clock period) so whole periods can be measured quickly.
module tb_pwm_generator_unit;

  localparam int unsigned Res = 10;

  logic CLK_i     = 1'b0;
  logic RESET_n_i = 1'b0;
  int   checks    = 0;
  int   errors    = 0;
  int   n;

  pwm_generator_unit_if #(.PWM_RESOLUTION_c(Res)) bus ();

  pwm_generator_unit #(
    .CLK_FREQ_c      (3072),
    .PWM_FREQ_c      (1),
    .PWM_RESOLUTION_c(Res)
  ) dut (
    .CLK_i    (CLK_i),
    .RESET_n_i(RESET_n_i),
    .pwm_io   (bus.slave)
  );

  initial forever #5 CLK_i = ~CLK_i;

  task automatic step();
    @(posedge CLK_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Number of clocks PWM_o stays at lvl, starting from the current sample.
  task automatic count_while(input logic lvl, input int limit, output int cnt);
    cnt = 0;
    while (bus.PWM_o === lvl && cnt < limit) begin
      step();
      cnt++;
    end
  endtask

  initial begin
    bus.EN_i        = 1'b1;
    bus.PWM_VALUE_i = 10'd128;
    #1;
    check("reset_out_t0", 32'(bus.PWM_o), 0);
    repeat (4) step();
    check("reset_out_held", 32'(bus.PWM_o), 0);

    // Release with EN held high: capture edge, then first high one clock later.
    RESET_n_i = 1'b1;
    step();
    check("capture_edge_low", 32'(bus.PWM_o), 0);
    step();
    check("first_high", 32'(bus.PWM_o), 1);
    count_while(1'b1, 4000, n);
    check("p1_high_128", n, 383);
    count_while(1'b0, 4000, n);
    check("p1_low_128", n, 2688);

    // Mid-period change to 64 only takes effect at the next boundary.
    bus.PWM_VALUE_i = 10'd64;
    count_while(1'b1, 4000, n);
    check("p2_high_128", n, 384);
    count_while(1'b0, 4000, n);
    check("p2_low_128", n, 2688);
    count_while(1'b1, 4000, n);
    check("p3_high_64", n, 192);
    bus.PWM_VALUE_i = 10'd512;
    count_while(1'b0, 4000, n);
    check("p3_low_64", n, 2880);
    count_while(1'b1, 4000, n);
    check("p4_high_512", n, 1536);
    bus.PWM_VALUE_i = 10'd1023;
    count_while(1'b0, 4000, n);
    check("p4_low_512", n, 1536);
    count_while(1'b1, 4000, n);
    check("p5_high_1023", n, 3069);
    count_while(1'b0, 4000, n);
    check("p5_low_1023", n, 3);

    // Drop EN mid-high.
    repeat (100) step();
    check("p6_high_before_drop", 32'(bus.PWM_o), 1);
    bus.EN_i = 1'b0;
    step();
    check("en_drop_low", 32'(bus.PWM_o), 0);
    count_while(1'b0, 1000, n);
    check("en_off_stays_low", n, 1000);

    // Re-enable with 1023: restart from step 0.
    bus.EN_i = 1'b1;
    step();
    check("reen_capture_low", 32'(bus.PWM_o), 0);
    step();
    check("reen_high", 32'(bus.PWM_o), 1);
    count_while(1'b1, 4000, n);
    check("reen_high_1023", n, 3068);
    count_while(1'b0, 4000, n);
    check("reen_low_1023", n, 3);
    check("reen_next_period_high", 32'(bus.PWM_o), 1);

    // EN low with value 0 on the same edge: output drops, value ignored.
    bus.EN_i        = 1'b0;
    bus.PWM_VALUE_i = 10'd0;
    step();
    check("off_zero_low", 32'(bus.PWM_o), 0);
    count_while(1'b0, 50, n);
    check("off_zero_hold", n, 50);

    // Value 0 while running: constant low for more than a period.
    bus.EN_i = 1'b1;
    count_while(1'b0, 4000, n);
    check("duty0_low", n, 4000);

    // Async reset mid-high, then resume only through an EN rising edge.
    bus.EN_i = 1'b0;
    step();
    bus.EN_i        = 1'b1;
    bus.PWM_VALUE_i = 10'd512;
    step();
    step();
    check("pre_reset_high", 32'(bus.PWM_o), 1);
    repeat (10) step();
    #3;
    RESET_n_i = 1'b0;
    #1;
    check("async_reset_low", 32'(bus.PWM_o), 0);
    repeat (3) step();
    check("reset_held_low", 32'(bus.PWM_o), 0);
    RESET_n_i = 1'b1;
    step();
    check("post_reset_capture_low", 32'(bus.PWM_o), 0);
    step();
    check("post_reset_high", 32'(bus.PWM_o), 1);
    count_while(1'b1, 4000, n);
    check("post_reset_high_512", n, 1535);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
